muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised, iterative multiply/divide unit for the CPU execute stage. It sits beside the single-cycle ALU and handles signed and unsigned multiply and divide through a start/busy/done handshake. Results go to a HI/LO register pair. Operand width is a parameter, and the unit takes one radix-2 step per cycle.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  muldiv_op_t: MULTU=0, MULT=1, DIVU=2, DIV=3.
- portA  in  WIDTH  multiplicand / dividend.
- portB  in  WIDTH  multiplier / divisor.
- abort  in  1  pipeline flush; cancels the operation in flight.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; results valid.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- zeroFlag  out  1  result is zero.
- negativeFlag  out  1  result MSB is set.
- divZeroFlag  out  1  last divide had divisor 0.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state=IDLE; hi=lo=0; all flags 0; busy=0; done=0.
- **Accept:** start=1 in IDLE or DONE latches op, sign info, and |portA|, |portB|.
  - |x| is taken only for signed ops.
  - Step counter loads WIDTH-1.
  - Next state is CALC.
  - start in CALC or FIX is ignored.
- **CALC, multiply:** shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle.
- **CALC exit:** counter reaches 0 → FIX.
- **FIX:**
  - Apply sign correction.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Register hi/lo and the flags.
  - Next state is DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE, unless start re-enters CALC.
- **Holding:** hi/lo/flags hold until the next FIX or the divide-by-zero path.
- **Divide by zero** (DIV/DIVU with portB=0 at accept):
  - Go directly to DONE.
  - hi=portA, lo=all ones, divZeroFlag=1.
  - zeroFlag and negativeFlag are computed from lo.
- **Signed overflow:** DIV of MIN by -1 gives lo=MIN, hi=0, with no error flag.
- **Flags:**
  - Multiply: zeroFlag=({hi,lo}==0), negativeFlag=hi[WIDTH-1].
  - Divide: zeroFlag=(lo==0), negativeFlag=lo[WIDTH-1].
  - divZeroFlag is cleared by every completed non-div-by-zero operation.
- **abort:**
  - In CALC or FIX: next state IDLE, no done, hi/lo/flags unchanged.
  - abort has priority over start in the same cycle.
  - In IDLE or DONE: no effect other than blocking start.
- **Reset mid-operation:** immediate return to reset values; no done.

## Timing
- **Latency:** start sampled at edge 0 → done high during the cycle after edge WIDTH+1. This is WIDTH+2 cycles of occupancy.
- **Divide-by-zero latency:** done high in the cycle after edge 0.
- **Output validity:** hi/lo/flags change only on the edge that enters DONE, and are stable while done=1.
- **busy:** rises the cycle after accept and falls as DONE is entered.
- **Back-to-back:** start during DONE begins a new operation with no idle cycle.
- **Output type:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package:** add muldiv_op_t (2-bit enum) and muldiv_state_t to cpu_types_pkg; word_t stays as is.
- **Interface:** add muldiv_if (.vh) with modports muldiv and tb, mirroring the ALU interface split.
- **Sub-module:** one natural sub-module, muldiv_signfix.
  - Combinational absolute-value and sign-correction logic.
  - Used both at accept and in FIX.
- **Sequencer:** FSM, counter and datapath in one module.

## Test plan
All scenarios use WIDTH=32.
1. MULTU 0xFFFFFFFF × 2 → hi=0x00000001, lo=0xFFFFFFFE; done exactly 33 cycles after the start edge; busy high for 33 cycles.
2. MULT -3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1, negativeFlag=1, zeroFlag=0.
3. DIV -7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 5 ÷ 0 → done in the next cycle, hi=5, lo=0xFFFFFFFF, divZeroFlag=1. A following MULTU 0 × 9 clears divZeroFlag and sets zeroFlag.
5. start at cycle 10 of CALC → ignored. abort at cycle 20 → IDLE with no done and hi/lo unchanged. start together with abort in IDLE → not accepted.
6. RST asserted mid-CALC → hi=lo=0, busy=0 immediately. A back-to-back start during DONE produces a second done 34 cycles after the first.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the multiply/divide unit's
// operation codes and sequencer states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    MULT  = 2'd1,
    DIVU  = 2'd2,
    DIV   = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done bundle for the multiply/divide unit, split into the
// unit side and the requester (bench) side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import cpu_types_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero_flag;
  logic             negative_flag;
  logic             div_zero_flag;

  modport muldiv (
    input  start, op, port_a, port_b, abort,
    output busy, done, hi, lo,
    output zero_flag, negative_flag, div_zero_flag
  );

  modport tb (
    output start, op, port_a, port_b, abort,
    input  busy, done, hi, lo,
    input  zero_flag, negative_flag, div_zero_flag
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Operand magnitudes at accept, and sign correction of the raw
// unsigned product / quotient / remainder at the end.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  output logic               neg_a,
  output logic               neg_b,
  input  logic               is_div,
  input  logic               sa,
  input  logic               sb,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;

  always_comb begin
    neg_a = signed_op & a_i[WIDTH-1];
    neg_b = signed_op & b_i[WIDTH-1];
    abs_a = neg_a ? -a_i : a_i;
    abs_b = neg_b ? -b_i : b_i;

    quo_raw = acc[WIDTH-1:0];
    rem_raw = acc[2*WIDTH-1:WIDTH];
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -quo_raw : quo_raw;
    // remainder follows the dividend's sign
    rem     = sa ? -rem_raw : rem_raw;

    res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div ? quo : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring
// divide, one bit per cycle, results held in HI/LO.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zeroFlag,
  output logic             negativeFlag,
  output logic             divZeroFlag
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               zf_q, zf_d;
  logic               nf_q, nf_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic               accept;

  muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .signed_op (op[0]),
    .a_i       (portA),
    .b_i       (portB),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .is_div    (div_q),
    .sa        (sa_q),
    .sb        (sb_q),
    .acc       (acc_q),
    .res_hi    (fix_hi),
    .res_lo    (fix_lo)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // trial subtract on the remainder shifted left by one dividend bit
    rem_s    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = rem_s - {1'b0, m_q};
    div_next = diff[WIDTH]
             ? {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
             : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    dz_d    = dz_q;
    accept  = start & ~abort;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          div_d = op[1];
          sa_d  = neg_a;
          sb_d  = neg_b;
          cnt_d = CW'(WIDTH - 1);
          m_d   = op[1] ? abs_b : abs_a;
          acc_d = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          if (op[1] && (portB == '0)) begin
            hi_d    = portA;
            lo_d    = '1;
            zf_d    = 1'b0;
            nf_d    = 1'b1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          zf_d    = div_q ? (fix_lo == '0)
                          : ({fix_hi, fix_lo} == '0);
          nf_d    = div_q ? fix_lo[WIDTH-1] : fix_hi[WIDTH-1];
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy         = (state_q == CALC) || (state_q == FIX);
  assign done         = (state_q == DONE);
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign zeroFlag     = zf_q;
  assign negativeFlag = nf_q;
  assign divZeroFlag  = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: results, flags, latency,
// divide-by-zero, abort, ignored start, reset and back-to-back issue.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         start;
  muldiv_op_t   op;
  logic [W-1:0] portA;
  logic [W-1:0] portB;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         zeroFlag;
  logic         negativeFlag;
  logic         divZeroFlag;

  int nerr = 0;
  int nchk = 0;
  int cyc;
  int bcnt;
  int seen;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .op           (op),
    .portA        (portA),
    .portB        (portB),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .zeroFlag     (zeroFlag),
    .negativeFlag (negativeFlag),
    .divZeroFlag  (divZeroFlag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // presents a request for one clock edge; returns at the next negedge
  task automatic issue(input muldiv_op_t o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    portA = a;
    portB = b;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c, output int bc);
    c  = 0;
    bc = 0;
    while (!done && c < 200) begin
      if (busy) bc++;
      @(negedge CLK);
      c++;
    end
  endtask

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op    = MULTU;
    portA = '0;
    portB = '0;
    repeat (2) @(negedge CLK);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_flags", 64'({zeroFlag, negativeFlag, divZeroFlag}), 64'h0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: MULTU, latency and busy length
    issue(MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_done(cyc, bcnt);
    check("multu_lat", 64'(cyc), 64'd33);
    check("multu_busy", 64'(bcnt), 64'd33);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    @(negedge CLK);
    check("done_pulse", 64'(done), 64'h0);

    // 2: MULT -3 x 5
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc, bcnt);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    check("mult_nz", 64'({negativeFlag, zeroFlag}), 64'h2);

    // 3: DIV -7 / 2, then MIN / -1
    @(negedge CLK);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bcnt);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    @(negedge CLK);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt);
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'h0);
    check("ovf_flags", 64'({negativeFlag, zeroFlag, divZeroFlag}),
          64'h4);

    // 4: divide by zero, then a zero product clears the flag
    @(negedge CLK);
    issue(DIVU, 32'd5, 32'd0);
    check("dz_lat", 64'(done), 64'h1);
    check("dz_hi", 64'(hi), 64'h5);
    check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("dz_flags", 64'({divZeroFlag, negativeFlag, zeroFlag}),
          64'h6);
    issue(MULTU, 32'd0, 32'd9);
    wait_done(cyc, bcnt);
    check("zero_lat", 64'(cyc), 64'd33);
    check("zero_flags", 64'({divZeroFlag, zeroFlag}), 64'h1);

    // 5: start ignored mid-CALC
    @(negedge CLK);
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    issue(MULTU, 32'd1, 32'd1);
    wait_done(cyc, bcnt);
    check("ign_lat", 64'(cyc + 10), 64'd33);
    check("ign_lo", 64'(lo), 64'd14);
    check("ign_hi", 64'(hi), 64'd2);

    // abort at cycle 20 of CALC
    @(negedge CLK);
    issue(MULT, 32'd6, 32'd7);
    repeat (19) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge CLK);
    end
    check("abort_nodone", 64'(seen), 64'h0);
    check("abort_hilo", {hi, lo}, {32'd2, 32'd14});

    // start with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    op    = MULTU;
    portA = 32'd3;
    portB = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 64'({busy, done}), 64'h0);

    // 6: reset mid-CALC
    issue(MULTU, 32'd6, 32'd7);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mrst_hilo", {hi, lo}, 64'h0);
    check("mrst_busy", 64'({busy, done}), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // back-to-back through DONE
    issue(MULTU, 32'd6, 32'd7);
    wait_done(cyc, bcnt);
    check("b2b_first", 64'(lo), 64'd42);
    issue(MULTU, 32'd3, 32'd5);
    wait_done(cyc, bcnt);
    check("b2b_gap", 64'(cyc + 1), 64'd34);
    check("b2b_second", 64'(lo), 64'd15);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
